// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: ARM condition codes, control word layout,
// default parameter values and the condition evaluation helper.
package id_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NUM_REGS_DEF = 16;
    localparam int unsigned CTRL_W_DEF   = 9;
    localparam int unsigned CNT_W_DEF    = 16;

    // Control word bit positions: {S, B, exe_cmd[3:0], mem_w, mem_r, wb_en}
    localparam int unsigned CTRL_WB_EN  = 0;
    localparam int unsigned CTRL_MEM_R  = 1;
    localparam int unsigned CTRL_MEM_W  = 2;
    localparam int unsigned CTRL_EXE_LO = 3;
    localparam int unsigned CTRL_EXE_HI = 6;
    localparam int unsigned CTRL_B      = 7;
    localparam int unsigned CTRL_S      = 8;

    typedef enum logic [3:0] {
        CondEq = 4'h0,
        CondNe = 4'h1,
        CondCs = 4'h2,
        CondCc = 4'h3,
        CondMi = 4'h4,
        CondPl = 4'h5,
        CondVs = 4'h6,
        CondVc = 4'h7,
        CondHi = 4'h8,
        CondLs = 4'h9,
        CondGe = 4'hA,
        CondLt = 4'hB,
        CondGt = 4'hC,
        CondLe = 4'hD,
        CondAl = 4'hE,
        CondNv = 4'hF
    } cond_e;

    // status is {N, Z, C, V}; the reserved NV encoding never executes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
        logic n, z, c, v, pass;
        n = status[3];
        z = status[2];
        c = status[1];
        v = status[0];
        unique case (cond_e'(cond))
            CondEq:  pass = z;
            CondNe:  pass = ~z;
            CondCs:  pass = c;
            CondCc:  pass = ~c;
            CondMi:  pass = n;
            CondPl:  pass = ~n;
            CondVs:  pass = v;
            CondVc:  pass = ~v;
            CondHi:  pass = c & ~z;
            CondLs:  pass = ~c | z;
            CondGe:  pass = (n == v);
            CondLt:  pass = (n != v);
            CondGt:  pass = ~z & (n == v);
            CondLe:  pass = z | (n != v);
            CondAl:  pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file with two read ports, one write port and write-through bypass,
// so a read in the same cycle as a write to that register sees the new value.
module reg_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned RA_W    = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [RA_W-1:0] raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [RA_W-1:0] raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [RA_W-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
        rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: operand fetch, condition check and the ID/EXE pipeline
// register with valid/ready handshake, flush, and stall/bubble performance counters.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned CTRL_W   = CTRL_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    localparam int unsigned RA_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [31:0]       instr,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              hazard,
    input  logic              flush,
    input  logic [3:0]        status,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_dest,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_val_rn,
    output logic [XLEN-1:0]   out_val_rm,
    output logic              out_imm,
    output logic [11:0]       out_shift_op,
    output logic [23:0]       out_simm24,
    output logic [RA_W-1:0]   out_dest,
    output logic [RA_W-1:0]   src1,
    output logic [RA_W-1:0]   src2,
    output logic              two_src,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Instruction register fields are 4 bits; fit them to the register address width.
    function automatic logic [RA_W-1:0] to_ra(input logic [3:0] field);
        logic [31:0] wide;
        wide = {28'b0, field};
        return wide[RA_W-1:0];
    endfunction

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rn_q, rn_d;
    logic [XLEN-1:0]   rm_q, rm_d;
    logic              imm_q, imm_d;
    logic [11:0]       shift_q, shift_d;
    logic [23:0]       simm_q, simm_d;
    logic [RA_W-1:0]   dest_q, dest_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic            mem_w;
    logic            accept;
    logic            update;
    logic            bubble_inc;
    logic            stall_inc;
    logic [XLEN-1:0] rdata_a;
    logic [XLEN-1:0] rdata_b;
    logic            unused_instr;

    assign unused_instr = ^{instr[27:26], instr[24]};

    assign mem_w   = ctrl_in[CTRL_MEM_W];
    assign src1    = to_ra(instr[19:16]);
    assign src2    = mem_w ? to_ra(instr[15:12]) : to_ra(instr[3:0]);
    assign two_src = mem_w | instr[25];

    // Reset gating keeps the stage from accepting until the first edge after release.
    assign in_ready = rst & ~hazard & ~flush & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    reg_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk_i     (clk),
        .rst_ni    (rst),
        .raddr_a_i (src1),
        .rdata_a_o (rdata_a),
        .raddr_b_i (src2),
        .rdata_b_o (rdata_b),
        .we_i      (wb_en),
        .waddr_i   (wb_dest),
        .wdata_i   (wb_data)
    );

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        imm_d   = imm_q;
        shift_d = shift_q;
        simm_d  = simm_q;
        dest_d  = dest_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = cond_pass(instr[31:28], status) ? ctrl_in : '0;
            pc_d    = pc_in;
            rn_d    = rdata_a;
            rm_d    = rdata_b;
            imm_d   = instr[25];
            shift_d = instr[11:0];
            simm_d  = instr[23:0];
            dest_d  = to_ra(instr[15:12]);
        end else if (!(valid_q && !out_ready)) begin
            valid_d = 1'b0;
        end
    end

    // The register is reloaded every cycle except while a valid entry is back-pressured.
    assign update     = flush | ~valid_q | out_ready;
    assign bubble_inc = update & (~valid_d | (ctrl_d == '0));
    assign stall_inc  = in_valid & ~in_ready;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (bubble_inc && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            pc_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            imm_q    <= 1'b0;
            shift_q  <= '0;
            simm_q   <= '0;
            dest_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            imm_q    <= imm_d;
            shift_q  <= shift_d;
            simm_q   <= simm_d;
            dest_q   <= dest_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_ctrl     = ctrl_q;
    assign out_pc       = pc_q;
    assign out_val_rn   = rn_q;
    assign out_val_rm   = rm_q;
    assign out_imm      = imm_q;
    assign out_shift_op = shift_q;
    assign out_simm24   = simm_q;
    assign out_dest     = dest_q;
    assign stall_cnt    = stall_q;
    assign bubble_cnt   = bubble_q;

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, register and write-back values.
REQ-002 SHALL have parameter NUM_REGS, default 16, register file depth (power of two); RA_W = log2(NUM_REGS).
REQ-003 SHALL have parameter CTRL_W, default 9, control word width, layout {S, B, exe_cmd[3:0], mem_w, mem_r, wb_en} at default.
REQ-004 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-005 Ports, in order: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  IF/ID holds a valid instruction; in_ready  out  1  stage accepts this cycle.
REQ-007 pc_in  in  XLEN  PC of the instruction; instr  in  32  instruction word; ctrl_in  in  CTRL_W  control unit output for instr.
REQ-008 hazard  in  1  hazard unit stall request; flush  in  1  taken-branch kill.
REQ-009 status  in  4  flags {N,Z,C,V}.
REQ-010 wb_en  in  1  write-back enable; wb_dest  in  RA_W  write-back register; wb_data  in  XLEN  write-back value.
REQ-011 out_ready  in  1  EXE accepts; out_valid  out  1  ID/EXE register holds a valid entry.
REQ-012 out_ctrl CTRL_W, out_pc XLEN, out_val_rn XLEN, out_val_rm XLEN, out_imm 1, out_shift_op 12, out_simm24 24, out_dest RA_W: all out, registered ID/EXE fields.
REQ-013 src1  out  RA_W, src2  out  RA_W, two_src  out  1: combinational, to the hazard unit.
REQ-014 stall_cnt  out  CNT_W, bubble_cnt  out  CNT_W: performance counters.

Function
REQ-015 src1 = instr[19:16]; src2 = instr[15:12] when ctrl_in mem_w is 1, else instr[3:0]; two_src = mem_w | instr[25].
REQ-016 Condition pass SHALL be evaluated from instr[31:28] against status using the ARM table EQ..AL; 4'b1111 SHALL be treated as fail.
REQ-017 in_ready = ~hazard & ~flush & (~out_valid | out_ready).
REQ-018 Accept = in_valid & in_ready; on accept, all out_* fields SHALL load at the next edge and out_valid SHALL become 1.
REQ-019 A failed condition on accept SHALL load out_ctrl = 0; all other fields load normally; out_valid = 1.
REQ-020 When out_valid=1, out_ready=0 and no flush, every out_* field SHALL hold.
REQ-021 No accept and (out_ready=1 or out_valid=0) SHALL give out_valid = 0 next cycle (bubble).
REQ-022 flush=1 SHALL clear out_valid next cycle, regardless of in_valid, hazard or out_ready.
REQ-023 The register file SHALL write wb_data to wb_dest on the rising edge when wb_en=1.
REQ-024 A read of register r SHALL return wb_data when wb_en=1 and wb_dest=r in the same cycle (write-through bypass).
REQ-025 out_val_rn SHALL read src1 and out_val_rm SHALL read src2.
REQ-026 out_imm = instr[25]; out_shift_op = instr[11:0]; out_simm24 = instr[23:0]; out_dest = instr[15:12] (zero-extended or truncated to RA_W).
REQ-027 stall_cnt SHALL increment each cycle in_valid=1 and in_ready=0.
REQ-028 bubble_cnt SHALL increment each cycle out_valid is loaded with 0 or with out_ctrl = 0.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-030 rst=0 SHALL asynchronously clear out_valid, all out_* fields, every register file entry and both counters to 0.
REQ-031 in_ready SHALL be 0 while rst=0; the first accept SHALL occur no earlier than the first rising edge after rst deasserts.
REQ-032 Reset asserted mid-stall SHALL discard the held entry; no output retains pre-reset data.

Structure
REQ-033 A shared package id_pkg SHALL hold the cond code enum, the control word field offsets, and the default parameter constants.
REQ-034 The register file SHALL be a sub-module reg_file (params XLEN, NUM_REGS; 2 read ports, 1 write port, bypass inside).
REQ-035 The condition check SHALL be a function in id_pkg.

Verification
REQ-036 Write R3=0xDEADBEEF via wb, then accept instr 0xE0813003 (ADD R3,R1,R3) -> out_val_rm=0xDEADBEEF, out_valid=1 next cycle.
REQ-037 wb_en=1, wb_dest=1, wb_data=0x55 in the same cycle as accepting src1=1 -> out_val_rn=0x55.
REQ-038 status Z=0, instr cond EQ (0x0...), ctrl_in=0x1FF -> out_ctrl=0, out_valid=1, bubble_cnt+1.
REQ-039 out_valid=1, out_ready=0 for 5 cycles with in_valid=1 -> fields stable, in_ready=0, stall_cnt=5.
REQ-040 hazard=1 with out_ready=1 -> out_valid=0 next cycle; flush together with in_valid=1 -> no accept, out_valid=0.
REQ-041 Preload stall_cnt near all-ones and hold the stall for 3 cycles -> counter stays 0xFFFF; assert rst mid-stall -> all outputs 0 immediately.
